ktc32_controller: RTL and testbench

KTC32_CONTROLLER -- requirements
Module: ktc32_controller

---
 rtl/ktc32_controller.sv | 229 ++++++++++++++++++++++
 tb/tb_ktc32_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ktc32_controller.sv
`default_nettype none
// ============================================================================
//  Module   : ktc32_controller
//  Purpose  : Multicycle control FSM for the KTC32 datapath. All outputs are
//             combinational from state, instr, zero and mem_ready.
//  Option   : KTC32_CTRL_TRAP_EN - illegal opcodes trap into HALT
//             (otherwise they execute as NOP and halted is tied low).
//  Revision : 1.0 - initial release
// ============================================================================
module ktc32_controller (
  input  logic        clk,
  input  logic        reset,       // asynchronous, active-low
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        memwrite,
  output logic        pcen,
  output logic        iord,
  output logic        irwrite,
  output logic        memtoreg,
  output logic        regwrite,
  output logic        alusrca,
  output logic        pcsrc,
  output logic [1:0]  alusrcb,
  output logic [2:0]  alucontrol,
  output logic [3:0]  state,
  output logic        halted
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ALUWB  = 4'd4,
    S_MEMADR = 4'd5,
    S_MEMRD  = 4'd6,
    S_MEMWB  = 4'd7,
    S_MEMWR  = 4'd8,
    S_BRANCH = 4'd9,
`ifdef KTC32_CTRL_TRAP_EN
    S_JUMP   = 4'd10,
    S_HALT   = 4'd11
`else
    S_JUMP   = 4'd10
`endif
  } state_t;

  localparam logic [5:0] OP_LW  = 6'h21;
  localparam logic [5:0] OP_SW  = 6'h23;
  localparam logic [5:0] OP_BEQ = 6'h25;
  localparam logic [5:0] OP_BNE = 6'h27;
  localparam logic [5:0] OP_JMP = 6'h29;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  state_t r_state;
  state_t w_next_state;

  logic [5:0] w_op;
  logic       w_is_r;
  logic       w_is_i;
  logic       w_is_mem;
  logic       w_is_br;

  // Immediate field is consumed by the datapath, not by control.
  logic unused_imm;
  assign unused_imm = ^instr[31:6];

  assign w_op     = instr[5:0];
  assign w_is_r   = (w_op[5:4] == 2'b00) && !w_op[0];
  assign w_is_i   = (w_op[5:4] == 2'b01) &&  w_op[0];
  assign w_is_mem = (w_op == OP_LW) || (w_op == OP_SW);
  assign w_is_br  = (w_op == OP_BEQ) || (w_op == OP_BNE);

  assign state = r_state;

`ifdef KTC32_CTRL_TRAP_EN
  assign halted = reset && (r_state == S_HALT);
`else
  assign halted = 1'b0;
`endif

  // State register; reset forces FETCH without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection and per-state datapath controls.
  always_comb begin
    w_next_state = r_state;
    mem_req      = 1'b0;
    memwrite     = 1'b0;
    pcen         = 1'b0;
    iord         = 1'b0;
    irwrite      = 1'b0;
    memtoreg     = 1'b0;
    regwrite     = 1'b0;
    alusrca      = 1'b0;
    pcsrc        = 1'b0;
    alusrcb      = 2'b00;
    alucontrol   = ALU_ADD;

    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        // PC increment and IR load happen only on the edge that
        // completes the instruction read.
        pcen    = mem_ready;
        irwrite = mem_ready;
        if (mem_ready) begin
          w_next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        // Precompute branch/jump target while the opcode is decoded.
        alusrcb = 2'b11;
        if (w_is_r) begin
          w_next_state = S_EXEC_R;
        end else if (w_is_i) begin
          w_next_state = S_EXEC_I;
        end else if (w_is_mem) begin
          w_next_state = S_MEMADR;
        end else if (w_is_br) begin
          w_next_state = S_BRANCH;
        end else if (w_op == OP_JMP) begin
          w_next_state = S_JUMP;
        end else begin
`ifdef KTC32_CTRL_TRAP_EN
          w_next_state = S_HALT;
`else
          w_next_state = S_FETCH;
`endif
        end
      end

      S_EXEC_R: begin
        alusrca      = 1'b1;
        alucontrol   = instr[3:1];
        w_next_state = S_ALUWB;
      end

      S_EXEC_I: begin
        alusrca      = 1'b1;
        alusrcb      = 2'b11;
        alucontrol   = instr[3:1];
        w_next_state = S_ALUWB;
      end

      S_ALUWB: begin
        regwrite     = 1'b1;
        w_next_state = S_FETCH;
      end

      S_MEMADR: begin
        alusrca      = 1'b1;
        alusrcb      = 2'b11;
        w_next_state = (w_op == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        iord    = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) begin
          w_next_state = S_MEMWB;
        end
      end

      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite     = 1'b1;
        w_next_state = S_FETCH;
      end

      S_MEMWR: begin
        iord     = 1'b1;
        mem_req  = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) begin
          w_next_state = S_FETCH;
        end
      end

      S_BRANCH: begin
        alusrca      = 1'b1;
        alucontrol   = ALU_SUB;
        pcsrc        = 1'b1;
        pcen         = (w_op == OP_BNE) ? ~zero : zero;
        w_next_state = S_FETCH;
      end

      S_JUMP: begin
        pcsrc        = 1'b1;
        pcen         = 1'b1;
        w_next_state = S_FETCH;
      end

`ifdef KTC32_CTRL_TRAP_EN
      S_HALT: begin
        w_next_state = S_HALT;
      end
`endif

      default: begin
        w_next_state = S_FETCH;
      end
    endcase

    // Reset must silence every enable immediately, including a bus
    // access that is in flight.
    if (!reset) begin
      mem_req  = 1'b0;
      memwrite = 1'b0;
      pcen     = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ktc32_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ktc32_controller
//  Purpose  : Directed, table-driven self-checking bench for ktc32_controller.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ktc32_controller;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, memwrite, pcen, iord, irwrite, memtoreg, regwrite;
  logic        alusrca, pcsrc, halted;
  logic [1:0]  alusrcb;
  logic [2:0]  alucontrol;
  logic [3:0]  state;

  ktc32_controller dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .memwrite   (memwrite),
    .pcen       (pcen),
    .iord       (iord),
    .irwrite    (irwrite),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .pcsrc      (pcsrc),
    .alusrcb    (alusrcb),
    .alucontrol (alucontrol),
    .state      (state),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // State encodings
  localparam logic [3:0] F = 4'd0, D = 4'd1, ER = 4'd2, EI = 4'd3, AWB = 4'd4;
  localparam logic [3:0] MA = 4'd5, MRD = 4'd6, MWB = 4'd7, MWR = 4'd8;
  localparam logic [3:0] BR = 4'd9, JP = 4'd10, HLT = 4'd11;

  // Control bundle: {mem_req,memwrite,pcen,iord,irwrite,memtoreg,regwrite,
  //                  alusrca,pcsrc,alusrcb[1:0],alucontrol[2:0]}
  localparam logic [13:0] C_F1  = 14'b1_0_1_0_1_0_0_0_0_01_000;
  localparam logic [13:0] C_F0  = 14'b1_0_0_0_0_0_0_0_0_01_000;
  localparam logic [13:0] C_DEC = 14'b0_0_0_0_0_0_0_0_0_11_000;
  localparam logic [13:0] C_AWB = 14'b0_0_0_0_0_0_1_0_0_00_000;
  localparam logic [13:0] C_MA  = 14'b0_0_0_0_0_0_0_1_0_11_000;
  localparam logic [13:0] C_MRD = 14'b1_0_0_1_0_0_0_0_0_00_000;
  localparam logic [13:0] C_MWB = 14'b0_0_0_0_0_1_1_0_0_00_000;
  localparam logic [13:0] C_MWR = 14'b1_1_0_1_0_0_0_0_0_00_000;
  localparam logic [13:0] C_BR1 = 14'b0_0_1_0_0_0_0_1_1_00_001;
  localparam logic [13:0] C_BR0 = 14'b0_0_0_0_0_0_0_1_1_00_001;
  localparam logic [13:0] C_JMP = 14'b0_0_1_0_0_0_0_0_1_00_000;
  localparam logic [13:0] C_ER0 = 14'b0_0_0_0_0_0_0_1_0_00_000; // ADD
  localparam logic [13:0] C_ER5 = 14'b0_0_0_0_0_0_0_1_0_00_101; // SLT
  localparam logic [13:0] C_EI4 = 14'b0_0_0_0_0_0_0_1_0_11_100; // XORI

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic        rdy;
    logic [3:0]  st;
    logic [13:0] ctl;
  } vec_t;

  localparam int NV = 33;
  vec_t tbl [NV];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(input logic [31:0] i, input logic z, input logic r,
                              input logic [3:0] s, input logic [13:0] c);
    vec_t v;
    v.instr = i; v.zero = z; v.rdy = r; v.st = s; v.ctl = c;
    return v;
  endfunction

  function automatic logic [13:0] ctl_now();
    return {mem_req, memwrite, pcen, iord, irwrite, memtoreg, regwrite,
            alusrca, pcsrc, alusrcb, alucontrol};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one row: drive inputs, check outputs of the current state, clock.
  task automatic run_row(input vec_t v, input int idx);
    instr = v.instr; zero = v.zero; mem_ready = v.rdy;
    #2;
    chk($sformatf("row%0d.state", idx), {28'd0, state}, {28'd0, v.st});
    chk($sformatf("row%0d.ctl", idx), {18'd0, ctl_now()}, {18'd0, v.ctl});
    @(posedge clk); #1;
  endtask

  initial begin
    // ADD r1,r2
    tbl[0]  = mk(32'h0000_0880, 0, 1, F,   C_F1);
    tbl[1]  = mk(32'h0000_0880, 0, 1, D,   C_DEC);
    tbl[2]  = mk(32'h0000_0880, 0, 1, ER,  C_ER0);
    tbl[3]  = mk(32'h0000_0880, 0, 1, AWB, C_AWB);
    // XORI with a three-cycle fetch wait
    tbl[4]  = mk(32'h0005_0019, 0, 0, F,   C_F0);
    tbl[5]  = mk(32'h0005_0019, 0, 0, F,   C_F0);
    tbl[6]  = mk(32'h0005_0019, 0, 0, F,   C_F0);
    tbl[7]  = mk(32'h0005_0019, 0, 1, F,   C_F1);
    tbl[8]  = mk(32'h0005_0019, 0, 1, D,   C_DEC);
    tbl[9]  = mk(32'h0005_0019, 0, 1, EI,  C_EI4);
    tbl[10] = mk(32'h0005_0019, 0, 1, AWB, C_AWB);
    // LW with one memory wait
    tbl[11] = mk(32'h0010_0821, 0, 1, F,   C_F1);
    tbl[12] = mk(32'h0010_0821, 0, 1, D,   C_DEC);
    tbl[13] = mk(32'h0010_0821, 0, 1, MA,  C_MA);
    tbl[14] = mk(32'h0010_0821, 0, 0, MRD, C_MRD);
    tbl[15] = mk(32'h0010_0821, 0, 1, MRD, C_MRD);
    tbl[16] = mk(32'h0010_0821, 0, 1, MWB, C_MWB);
    // BEQ taken, then not taken
    tbl[17] = mk(32'hFFFC_0025, 1, 1, F,   C_F1);
    tbl[18] = mk(32'hFFFC_0025, 1, 1, D,   C_DEC);
    tbl[19] = mk(32'hFFFC_0025, 1, 1, BR,  C_BR1);
    tbl[20] = mk(32'hFFFC_0025, 0, 1, F,   C_F1);
    tbl[21] = mk(32'hFFFC_0025, 0, 1, D,   C_DEC);
    tbl[22] = mk(32'hFFFC_0025, 0, 1, BR,  C_BR0);
    // BNE with zero=0 -> taken
    tbl[23] = mk(32'h0004_0027, 0, 1, F,   C_F1);
    tbl[24] = mk(32'h0004_0027, 0, 1, D,   C_DEC);
    tbl[25] = mk(32'h0004_0027, 0, 1, BR,  C_BR1);
    // JMP
    tbl[26] = mk(32'h0100_0029, 0, 1, F,   C_F1);
    tbl[27] = mk(32'h0100_0029, 0, 1, D,   C_DEC);
    tbl[28] = mk(32'h0100_0029, 0, 1, JP,  C_JMP);
    // SLT (R-type, op 101)
    tbl[29] = mk(32'h0000_000A, 0, 1, F,   C_F1);
    tbl[30] = mk(32'h0000_000A, 0, 1, D,   C_DEC);
    tbl[31] = mk(32'h0000_000A, 0, 1, ER,  C_ER5);
    tbl[32] = mk(32'h0000_000A, 0, 1, AWB, C_AWB);

    // Reset behaviour
    reset = 1'b0; instr = 32'h0; zero = 1'b0; mem_ready = 1'b1;
    #12;
    chk("reset.state",    {28'd0, state}, {28'd0, F});
    chk("reset.mem_req",  {31'd0, mem_req}, 32'd0);
    chk("reset.pcen",     {31'd0, pcen}, 32'd0);
    chk("reset.irwrite",  {31'd0, irwrite}, 32'd0);
    chk("reset.halted",   {31'd0, halted}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("release.mem_req", {31'd0, mem_req}, 32'd1);

    for (int i = 0; i < NV; i++) begin
      run_row(tbl[i], i);
    end

    // Illegal opcode 0x3E
    run_row(mk(32'h0000_003E, 0, 1, F, C_F1), 100);
    run_row(mk(32'h0000_003E, 0, 1, D, C_DEC), 101);
`ifdef KTC32_CTRL_TRAP_EN
    for (int k = 0; k < 10; k++) begin
      #2;
      chk($sformatf("halt%0d.state", k),  {28'd0, state}, {28'd0, HLT});
      chk($sformatf("halt%0d.halted", k), {31'd0, halted}, 32'd1);
      chk($sformatf("halt%0d.ctl", k),    {18'd0, ctl_now()}, 32'd0);
      @(posedge clk); #1;
    end
`else
    #2;
    chk("illegal.state",  {28'd0, state}, {28'd0, F});
    chk("illegal.mem_req", {31'd0, mem_req}, 32'd1);
    chk("illegal.halted",  {31'd0, halted}, 32'd0);
    @(posedge clk); #1;
`endif

    // Reset pulse between edges returns the FSM to FETCH
    reset = 1'b0; #3; reset = 1'b1; #1;
    chk("pulse.state", {28'd0, state}, {28'd0, F});

    // SW stalled in MEMWR, then reset asserted mid-cycle
    run_row(mk(32'h0008_0023, 0, 1, F,  C_F1), 200);
    run_row(mk(32'h0008_0023, 0, 1, D,  C_DEC), 201);
    run_row(mk(32'h0008_0023, 0, 1, MA, C_MA), 202);
    run_row(mk(32'h0008_0023, 0, 0, MWR, C_MWR), 203);
    #2;
    chk("memwr.hold.state",    {28'd0, state}, {28'd0, MWR});
    chk("memwr.hold.memwrite", {31'd0, memwrite}, 32'd1);
    reset = 1'b0;
    #1;
    chk("memwr.rst.memwrite", {31'd0, memwrite}, 32'd0);
    chk("memwr.rst.mem_req",  {31'd0, mem_req}, 32'd0);
    chk("memwr.rst.state",    {28'd0, state}, {28'd0, F});
    #10;
    reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends on its own.
  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
